// File: rtl/onehot_bank_drain_pkg.sv
// Shared defaults, FSM encoding and strobe-shape helper for the one-hot register bank drain.
package onehot_bank_drain_pkg;

   localparam int NSLOT_DEF = 4;
   localparam int WIDTH_DEF = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // True when exactly one bit is set; callers zero-extend their strobe to 32 bits.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/onehot_bank_drain_if.sv
// Strobe-write and valid/ready readout signals of the one-hot register bank.
interface onehot_bank_drain_if #(
   parameter int NSLOT = 4,
   parameter int WIDTH = 4
);
   logic [NSLOT-1:0]         wr_sel;
   logic [WIDTH-1:0]         wr_data;
   logic                     rd_valid;
   logic                     rd_ready;
   logic [WIDTH-1:0]         rd_data;
   logic [$clog2(NSLOT)-1:0] rd_slot;
   logic                     overrun;
   logic                     sel_err;

   modport master (
      output wr_sel, wr_data, rd_ready,
      input  rd_valid, rd_data, rd_slot, overrun, sel_err
   );

   modport slave (
      input  wr_sel, wr_data, rd_ready,
      output rd_valid, rd_data, rd_slot, overrun, sel_err
   );
endinterface

// File: rtl/onehot_bank_drain_rr_pick.sv
// Round-robin finder: first set bit of fresh searching last+1, last+2, ... modulo NSLOT.
module onehot_bank_drain_rr_pick
   import onehot_bank_drain_pkg::*;
#(
   parameter int NSLOT = NSLOT_DEF,
   localparam int SW   = $clog2(NSLOT)
) (
   input  logic [NSLOT-1:0] fresh,
   input  logic [SW-1:0]    last,
   output logic             found,
   output logic [SW-1:0]    idx
);

   int          j;
   logic [SW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      cand  = '0;
      for (int k = 1; k <= NSLOT; k++) begin
         j    = (int'(last) + k) % NSLOT;
         cand = SW'(j);
         if (!found && fresh[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/onehot_bank_drain.sv
// One-hot strobed register bank drained round-robin over a valid/ready port.
//  state   | meaning
//  IDLE    | nothing presented; load the next fresh slot as soon as one exists
//  PRESENT | rd_data/rd_slot held valid until the consumer accepts
module onehot_bank_drain
   import onehot_bank_drain_pkg::*;
#(
   parameter int NSLOT = NSLOT_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input logic              clk,
   input logic              rst_n,
   onehot_bank_drain_if.slave bus
);

   localparam int SW = $clog2(NSLOT);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] slots [NSLOT];
   logic [NSLOT-1:0] fresh;
   logic [SW-1:0]    last;
   logic             found;
   logic [SW-1:0]    pick;
   logic             wr_ok, wr_bad, load_en;
   logic [NSLOT-1:0] load_mask;
   logic [WIDTH-1:0] rd_data_q;
   logic [SW-1:0]    rd_slot_q;
   logic             overrun_q, sel_err_q;

   assign wr_ok  = is_onehot(32'(bus.wr_sel));
   assign wr_bad = (|bus.wr_sel) && !wr_ok;

   onehot_bank_drain_rr_pick #(.NSLOT(NSLOT)) u_pick (
      .fresh (fresh),
      .last  (last),
      .found (found),
      .idx   (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Pick uses the registered fresh vector, so a same-edge write never affects this edge's choice.
   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               load_en   = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.rd_ready) begin
               if (found) load_en   = 1'b1;
               else       state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load_mask = load_en ? (NSLOT'(1) << pick) : '0;

   // Clear-then-set: a slot loaded and rewritten on the same edge stays fresh with the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOT; i++) slots[i] <= '0;
         fresh     <= '0;
         last      <= SW'(NSLOT - 1);
         rd_data_q <= '0;
         rd_slot_q <= '0;
         overrun_q <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            if (wr_ok && bus.wr_sel[i]) slots[i] <= bus.wr_data;
         end
         fresh <= (fresh & ~load_mask) | (wr_ok ? bus.wr_sel : '0);
         if (load_en) begin
            rd_data_q <= slots[pick];
            rd_slot_q <= pick;
            last      <= pick;
         end
         overrun_q <= wr_ok && (|(bus.wr_sel & fresh & ~load_mask));
         sel_err_q <= wr_bad;
      end
   end

   assign bus.rd_valid = (state == PRESENT);
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_slot  = rd_slot_q;
   assign bus.overrun  = overrun_q;
   assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_onehot_bank_drain.sv
// Directed bench for onehot_bank_drain: expected words are queued as writes are driven, popped as words appear.
module tb_onehot_bank_drain;

   localparam int NSLOT = 4;
   localparam int WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [1:0]       s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   onehot_bank_drain_if #(.NSLOT(NSLOT), .WIDTH(WIDTH)) bus ();

   onehot_bank_drain #(.NSLOT(NSLOT), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wr(input logic [NSLOT-1:0] sel, input logic [WIDTH-1:0] data);
      bus.wr_sel  = sel;
      bus.wr_data = data;
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      sb.push_back(e);
   endtask

   task automatic expect_word(input string tag);
      exp_t e;
      chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(bus.rd_data), 32'(e.d));
         chk({tag, "_slot"}, 32'(bus.rd_slot), 32'(e.s));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.wr_sel   = '0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      #12;
      chk("rst_valid",   32'(bus.rd_valid), 32'd0);
      chk("rst_data",    32'(bus.rd_data),  32'd0);
      chk("rst_slot",    32'(bus.rd_slot),  32'd0);
      chk("rst_overrun", 32'(bus.overrun),  32'd0);
      chk("rst_sel_err", 32'(bus.sel_err),  32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1: single write, two-edge latency, drop after accept
      wr(4'b0001, 4'hA); push(4'hA, 2'd0);
      step();
      wr(4'b0000, 4'h0);
      chk("t1_lat_e0", 32'(bus.rd_valid), 32'd0);
      step();
      expect_word("t1_word");
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      chk("t1_drop", 32'(bus.rd_valid), 32'd0);

      // 2: burst of four writes held, then drained back-to-back
      for (int i = 0; i < 4; i++) begin
         wr(4'(1 << i), 4'(i + 1)); push(4'(i + 1), 2'(i));
         step();
      end
      wr(4'b0000, 4'h0);
      expect_word("t2_first");
      step(); step();
      chk("t2_hold_data", 32'(bus.rd_data), 32'd1);
      chk("t2_hold_slot", 32'(bus.rd_slot), 32'd0);
      chk("t2_hold_valid", 32'(bus.rd_valid), 32'd1);
      bus.rd_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step();
         expect_word($sformatf("t2_b2b%0d", i));
      end
      step();
      bus.rd_ready = 1'b0;
      chk("t2_empty", 32'(bus.rd_valid), 32'd0);

      // 3: overwrite of an unread slot
      wr(4'b0001, 4'h7); push(4'h7, 2'd0);
      step();
      wr(4'b0100, 4'h5);
      step();
      chk("t3_no_ovr", 32'(bus.overrun), 32'd0);
      wr(4'b0100, 4'h6); push(4'h6, 2'd2);
      step();
      wr(4'b0000, 4'h0);
      chk("t3_ovr", 32'(bus.overrun), 32'd1);
      expect_word("t3_w0");
      step();
      chk("t3_ovr_pulse", 32'(bus.overrun), 32'd0);
      bus.rd_ready = 1'b1;
      step();
      expect_word("t3_w2");
      step();
      bus.rd_ready = 1'b0;
      chk("t3_empty", 32'(bus.rd_valid), 32'd0);

      // 4: multi-hot strobe rejected
      wr(4'b0101, 4'hF);
      step();
      wr(4'b0000, 4'h0);
      chk("t4_sel_err", 32'(bus.sel_err), 32'd1);
      chk("t4_valid0", 32'(bus.rd_valid), 32'd0);
      step();
      chk("t4_sel_err_pulse", 32'(bus.sel_err), 32'd0);
      chk("t4_valid1", 32'(bus.rd_valid), 32'd0);
      step();
      chk("t4_valid2", 32'(bus.rd_valid), 32'd0);

      // 5: round-robin resumes after the last served slot
      wr(4'b0010, 4'h9); push(4'h9, 2'd1);
      step();
      wr(4'b0001, 4'hA);
      step();
      wr(4'b1000, 4'hB); push(4'hB, 2'd3); push(4'hA, 2'd0);
      step();
      wr(4'b0000, 4'h0);
      expect_word("t5_s1");
      bus.rd_ready = 1'b1;
      step();
      expect_word("t5_s3");
      step();
      expect_word("t5_s0");
      step();
      bus.rd_ready = 1'b0;
      chk("t5_empty", 32'(bus.rd_valid), 32'd0);

      // 6: reset during presentation with a fresh slot pending
      wr(4'b0001, 4'hC);
      step();
      wr(4'b0010, 4'hD);
      step();
      wr(4'b0000, 4'h0);
      chk("t6_pre_valid", 32'(bus.rd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
      chk("t6_rst_data",  32'(bus.rd_data),  32'd0);
      chk("t6_rst_slot",  32'(bus.rd_slot),  32'd0);
      sb.delete();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t6_post_valid%0d", i), 32'(bus.rd_valid), 32'd0);
      end

      // 7: load and rewrite of the same slot on one edge
      wr(4'b0001, 4'h1); push(4'h1, 2'd0);
      step();
      wr(4'b0001, 4'h2); push(4'h2, 2'd0);
      step();
      wr(4'b0000, 4'h0);
      chk("t7_no_ovr", 32'(bus.overrun), 32'd0);
      expect_word("t7_old");
      bus.rd_ready = 1'b1;
      step();
      expect_word("t7_new");
      step();
      bus.rd_ready = 1'b0;
      chk("t7_empty", 32'(bus.rd_valid), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
